// File: rtl/mem_access_stage.sv
// RV32 MEM stage: register-file data memory with B/H/W loads and stores plus a valid/ready memory dump.
// Define MEM_MISALIGN_TRAP_EN to drop misaligned accesses and flag them; otherwise addresses are force-aligned.
module mem_access_stage #(
   parameter int NB_DATA = 32,
   parameter int NB_ADDR = 5
) (
   input  logic               i_clk,
   input  logic               i_reset,
   input  logic               i_mem_read,
   input  logic               i_mem_write,
   input  logic [2:0]         i_funct3,
   input  logic [NB_DATA-1:0] i_alu_result,
   input  logic [NB_DATA-1:0] i_write_data,
   input  logic [1:0]         i_pipeline_mode,
   input  logic               i_execute_instruct,
   input  logic               i_dump_start,
   input  logic               i_dump_ready,
   output logic [NB_DATA-1:0] o_read_data,
   output logic               o_dump_valid,
   output logic [NB_ADDR-1:0] o_dump_addr,
   output logic [NB_DATA-1:0] o_dump_data,
   output logic               o_dump_done,
   output logic               o_busy,
   output logic               o_misaligned
);
   localparam int MEM_DEPTH = 2**NB_ADDR;
   localparam int NB_BYTES  = NB_DATA/8;

   typedef enum logic [1:0] {IDLE, SEND, DONE} dump_state_t;

   dump_state_t                       state;
   logic [MEM_DEPTH-1:0][NB_DATA-1:0] mem;
   logic [NB_ADDR-1:0]                word_idx, ptr;
   logic [1:0]                        lane, eff_lane;
   logic                              is_half, is_word, adv, misalign, store_en;
   logic [NB_DATA-1:0]                rd_word, wdata;
   logic [NB_BYTES-1:0]               wmask;
   logic [7:0]                        rd_byte;
   logic [15:0]                       rd_half;
   logic                              unused_addr_hi;

   // Address bits above the 128 B window are deliberately ignored (wrap-around).
   assign unused_addr_hi = ^i_alu_result[NB_DATA-1:NB_ADDR+2];
   assign word_idx = i_alu_result[NB_ADDR+1:2];
   assign lane     = i_alu_result[1:0];
   assign is_half  = (i_funct3[1:0] == 2'b01);
   assign is_word  = i_funct3[1];
   assign adv      = (i_pipeline_mode == 2'b01) | ((i_pipeline_mode == 2'b11) & i_execute_instruct);

`ifdef MEM_MISALIGN_TRAP_EN
   assign misalign = (i_mem_read | i_mem_write) &
                     ((is_half & lane[0]) | (is_word & (lane != 2'b00)));
   assign eff_lane = lane;

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset)              o_misaligned <= 1'b0;
      else if (misalign & adv)  o_misaligned <= 1'b1;
   end
`else
   assign misalign     = 1'b0;
   assign eff_lane     = is_word ? 2'b00 : (is_half ? {lane[1], 1'b0} : lane);
   assign o_misaligned = 1'b0;
`endif

   assign store_en = i_mem_write & adv & ~o_busy & ~misalign;

   // Memory is registered, so a same-cycle load sees the pre-write word.
   assign rd_word = mem[word_idx];
   assign rd_byte = rd_word[{eff_lane, 3'b000} +: 8];
   assign rd_half = rd_word[{eff_lane[1], 4'b0000} +: 16];

   always_comb begin
      o_read_data = '0;
      if (i_mem_read & ~misalign) begin
         if (is_word)
            o_read_data = rd_word;
         else if (is_half)
            o_read_data = {{(NB_DATA-16){~i_funct3[2] & rd_half[15]}}, rd_half};
         else
            o_read_data = {{(NB_DATA-8){~i_funct3[2] & rd_byte[7]}}, rd_byte};
      end
   end

   always_comb begin
      wdata = i_write_data;
      wmask = '1;
      if (is_half) begin
         wdata = {(NB_BYTES/2){i_write_data[15:0]}};
         wmask = '0;
         wmask[{eff_lane[1], 1'b0} +: 2] = 2'b11;
      end else if (!is_word) begin
         wdata = {NB_BYTES{i_write_data[7:0]}};
         wmask = '0;
         wmask[eff_lane] = 1'b1;
      end
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         mem <= '0;
      end else if (store_en) begin
         for (int b = 0; b < NB_BYTES; b++)
            if (wmask[b]) mem[word_idx][8*b +: 8] <= wdata[8*b +: 8];
      end
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state        <= IDLE;
         ptr          <= '0;
         o_dump_valid <= 1'b0;
         o_dump_done  <= 1'b0;
         o_busy       <= 1'b0;
      end else begin
         case (state)
            IDLE: if (i_dump_start) begin
               state        <= SEND;
               ptr          <= '0;
               o_dump_valid <= 1'b1;
               o_busy       <= 1'b1;
            end
            SEND: if (i_dump_ready) begin
               if (ptr == NB_ADDR'(MEM_DEPTH-1)) begin
                  state        <= DONE;
                  o_dump_valid <= 1'b0;
                  o_dump_done  <= 1'b1;
               end else begin
                  ptr <= ptr + 1'b1;
               end
            end
            DONE: begin
               state       <= IDLE;
               o_dump_done <= 1'b0;
               o_busy      <= 1'b0;
            end
            default: begin
               state        <= IDLE;
               o_dump_valid <= 1'b0;
               o_dump_done  <= 1'b0;
               o_busy       <= 1'b0;
            end
         endcase
      end
   end

   assign o_dump_addr = ptr;
   assign o_dump_data = mem[ptr];
endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: directed cases plus random traffic against a byte-array memory model.
module tb_mem_access_stage;
   logic        i_clk = 1'b0, i_reset = 1'b0;
   logic        i_mem_read = 0, i_mem_write = 0, i_execute_instruct = 0;
   logic        i_dump_start = 0, i_dump_ready = 0;
   logic [2:0]  i_funct3 = 0;
   logic [31:0] i_alu_result = 0, i_write_data = 0;
   logic [1:0]  i_pipeline_mode = 2'b01;
   logic [31:0] o_read_data, o_dump_data;
   logic [4:0]  o_dump_addr;
   logic        o_dump_valid, o_dump_done, o_busy, o_misaligned;

   mem_access_stage #(.NB_DATA(32), .NB_ADDR(5)) dut (
      .i_clk(i_clk), .i_reset(i_reset), .i_mem_read(i_mem_read), .i_mem_write(i_mem_write),
      .i_funct3(i_funct3), .i_alu_result(i_alu_result), .i_write_data(i_write_data),
      .i_pipeline_mode(i_pipeline_mode), .i_execute_instruct(i_execute_instruct),
      .i_dump_start(i_dump_start), .i_dump_ready(i_dump_ready), .o_read_data(o_read_data),
      .o_dump_valid(o_dump_valid), .o_dump_addr(o_dump_addr), .o_dump_data(o_dump_data),
      .o_dump_done(o_dump_done), .o_busy(o_busy), .o_misaligned(o_misaligned));

   always #5 i_clk = ~i_clk;

`ifdef MEM_MISALIGN_TRAP_EN
   localparam bit TRAP = 1'b1;
`else
   localparam bit TRAP = 1'b0;
`endif

   int n_checks = 0, n_errs = 0;
   byte unsigned mm[128];
   bit m_mis = 0, m_busy = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errs++;
         $display("FAIL %s: got %08h expected %08h", tag, got, exp);
      end
   endtask

   function automatic int unsigned sz_of(input logic [2:0] f3);
      return (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
   endfunction

   function automatic bit m_misal(input logic [31:0] addr, input logic [2:0] f3);
      return TRAP && ((addr % sz_of(f3)) != 0);
   endfunction

   function automatic int unsigned m_base(input logic [31:0] addr, input logic [2:0] f3);
      int unsigned a = addr % 128;
      return TRAP ? a : a - (a % sz_of(f3));
   endfunction

   function automatic logic [31:0] m_load(input logic [31:0] addr, input logic [2:0] f3);
      int unsigned sz = sz_of(f3), a = m_base(addr, f3), v = 0;
      if (m_misal(addr, f3)) return 0;
      for (int i = 0; i < sz; i++) v += mm[a+i] * (1 << (8*i));
      if (!f3[2] && sz < 4 && v >= (1 << (8*sz-1))) v = v - (1 << (8*sz));
      return v;
   endfunction

   task automatic m_clear();
      for (int i = 0; i < 128; i++) mm[i] = 0;
      m_mis = 0;
   endtask

   task automatic drive(input bit rd, input bit wr, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [1:0] mode, input bit ex);
      i_mem_read = rd; i_mem_write = wr; i_funct3 = f3; i_alu_result = addr;
      i_write_data = wd; i_pipeline_mode = mode; i_execute_instruct = ex;
   endtask

   // Advance the model to match what the DUT commits at the coming edge.
   task automatic tick();
      bit adv, mis;
      int unsigned a;
      adv = (i_pipeline_mode == 2'b01) || (i_pipeline_mode == 2'b11 && i_execute_instruct);
      mis = (i_mem_read || i_mem_write) && m_misal(i_alu_result, i_funct3);
      if (i_mem_write && adv && !m_busy && !mis) begin
         a = m_base(i_alu_result, i_funct3);
         for (int i = 0; i < sz_of(i_funct3); i++) mm[a+i] = 8'((i_write_data >> (8*i)) & 32'hFF);
      end
      if (mis && adv) m_mis = 1;
      @(posedge i_clk); #1;
   endtask

   task automatic do_reset();
      drive(0, 0, 0, 0, 0, 2'b01, 0);
      i_dump_start = 0; i_dump_ready = 0;
      i_reset = 1; m_clear(); m_busy = 0;
      repeat (2) @(posedge i_clk);
      #1 i_reset = 0;
   endtask

   task automatic chk_load(input string tag);
      chk(tag, o_read_data, i_mem_read ? m_load(i_alu_result, i_funct3) : 32'h0);
   endtask

   initial begin
      int hs, dones, cyc;
      bit fin, pv, wrote, restarted;
      logic [4:0] pa;
      logic [31:0] pd;
      logic [2:0] f3;
      int op;

      // Reset state
      i_reset = 1; m_clear();
      #3;
      drive(1, 0, 3'b010, 0, 0, 2'b01, 0);
      #1;
      chk("rst_read", o_read_data, 0);
      chk("rst_busy", o_busy, 0);
      chk("rst_valid", o_dump_valid, 0);
      chk("rst_done", o_dump_done, 0);
      chk("rst_mis", o_misaligned, 0);
      @(posedge i_clk); #1 i_reset = 0;

      // Continuous-mode loads of every width/sign
      drive(0, 1, 3'b010, 32'h08, 32'hDEADBEEF, 2'b01, 0); tick();
      drive(1, 0, 3'b010, 32'h08, 0, 2'b01, 0); #1 chk("lw_08", o_read_data, 32'hDEADBEEF);
      drive(1, 0, 3'b000, 32'h08, 0, 2'b01, 0); #1 chk("lb_08", o_read_data, 32'hFFFFFFEF);
      drive(1, 0, 3'b100, 32'h0B, 0, 2'b01, 0); #1 chk("lbu_0b", o_read_data, 32'h000000DE);
      drive(1, 0, 3'b001, 32'h0A, 0, 2'b01, 0); #1 chk("lh_0a", o_read_data, 32'hFFFFDEAD);
      drive(0, 0, 3'b010, 32'h08, 0, 2'b01, 0); #1 chk("no_read", o_read_data, 0);
      drive(1, 0, 3'b010, 32'h88, 0, 2'b01, 0); #1 chk("lw_wrap", o_read_data, 32'hDEADBEEF);

      // Partial stores preserve neighbouring bytes
      drive(0, 1, 3'b000, 32'h09, 32'h55, 2'b01, 0); tick();
      drive(1, 0, 3'b010, 32'h08, 0, 2'b01, 0); #1 chk("sb_09", o_read_data, 32'hDEAD55EF);
      drive(0, 1, 3'b001, 32'h0A, 32'h1234, 2'b01, 0); tick();
      drive(1, 0, 3'b010, 32'h08, 0, 2'b01, 0); #1 chk("sh_0a", o_read_data, 32'h123455EF);

      // Stepwise mode: store only commits on the step pulse
      drive(0, 1, 3'b010, 32'h10, 32'hA5A5A5A5, 2'b11, 0);
      repeat (5) tick();
      drive(1, 0, 3'b010, 32'h10, 0, 2'b11, 0); #1 chk("step_hold", o_read_data, 0);
      drive(0, 1, 3'b010, 32'h10, 32'hA5A5A5A5, 2'b11, 1); tick();
      drive(1, 0, 3'b010, 32'h10, 0, 2'b11, 0); #1 chk("step_go", o_read_data, 32'hA5A5A5A5);

      // Load + store together: load sees old word, store lands
      drive(1, 1, 3'b010, 32'h10, 32'h11223344, 2'b01, 0); #1 chk("rw_old", o_read_data, 32'hA5A5A5A5);
      tick();
      drive(1, 0, 3'b010, 32'h10, 0, 2'b01, 0); #1 chk("rw_new", o_read_data, 32'h11223344);

      // Misaligned word store
      drive(0, 1, 3'b010, 32'h06, 32'h1, 2'b01, 0); tick();
      drive(1, 0, 3'b010, 32'h04, 0, 2'b01, 0); #1 chk("mis_store", o_read_data, TRAP ? 32'h0 : 32'h1);
      chk("mis_flag", o_misaligned, TRAP);
      drive(1, 0, 3'b010, 32'h06, 0, 2'b01, 0); #1 chk("mis_load", o_read_data, TRAP ? 32'h0 : 32'h1);
      repeat (3) tick();
      chk("mis_sticky", o_misaligned, TRAP);
      do_reset();
      chk("mis_cleared", o_misaligned, 0);

      // Random traffic
      for (int n = 0; n < 400; n++) begin
         op = $urandom_range(0, 3);
         case ($urandom_range(0, 4))
            0: f3 = 3'b000; 1: f3 = 3'b001; 2: f3 = 3'b010; 3: f3 = 3'b100; default: f3 = 3'b101;
         endcase
         if (op >= 2 && f3[2]) f3[2] = 1'b0;
         drive(op == 1 || op == 3, op >= 2, f3, $urandom_range(0, 255), $urandom,
               2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
         #1 chk_load("rnd_load");
         tick();
         chk("rnd_mis", o_misaligned, m_mis);
      end

      // Dump with ready toggling, mid-dump store and restart
      do_reset();
      for (int k = 0; k < 32; k++) begin
         drive(0, 1, 3'b010, k*4, k*3, 2'b01, 0); tick();
      end
      drive(0, 0, 0, 0, 0, 2'b01, 0);
      i_dump_start = 1; tick(); i_dump_start = 0; m_busy = 1;
      hs = 0; dones = 0; fin = 0; pv = 0; wrote = 0; restarted = 0; pa = 0; pd = 0;
      for (cyc = 0; cyc < 300 && !fin; cyc++) begin
         i_dump_ready = cyc[0];
         if (hs == 10 && !wrote) begin drive(0, 1, 3'b010, 32'h20, 32'hFFFFFFFF, 2'b01, 0); wrote = 1; end
         else drive(0, 0, 0, 0, 0, 2'b01, 0);
         i_dump_start = (hs == 15 && !restarted);
         if (i_dump_start) restarted = 1;
         #1;
         if (pv) begin
            chk("dump_hold_addr", o_dump_addr, pa);
            chk("dump_hold_data", o_dump_data, pd);
         end
         if (o_dump_done) begin dones++; fin = 1; end
         if (o_dump_valid && i_dump_ready) begin
            chk("dump_addr", o_dump_addr, hs);
            chk("dump_data", o_dump_data, hs*3);
            hs++;
         end
         pv = o_dump_valid && !i_dump_ready; pa = o_dump_addr; pd = o_dump_data;
         tick();
      end
      i_dump_start = 0; i_dump_ready = 1;
      chk("dump_count", hs, 32);
      chk("dump_done_seen", fin, 1);
      m_busy = 0;
      chk("dump_idle_busy", o_busy, 0);
      for (int i = 0; i < 5; i++) begin
         if (o_dump_done) dones++;
         chk("dump_no_restart", o_dump_valid, 0);
         tick();
      end
      chk("dump_done_pulses", dones, 1);
      drive(1, 0, 3'b010, 32'h20, 0, 2'b01, 0); #1 chk("dump_sw_blocked", o_read_data, m_load(32'h20, 3'b010));

      // Reset mid-dump
      drive(0, 0, 0, 0, 0, 2'b01, 0);
      i_dump_ready = 1; i_dump_start = 1; tick(); i_dump_start = 0;
      hs = 0;
      for (cyc = 0; cyc < 100 && hs < 7; cyc++) begin
         if (o_dump_valid) hs++;
         tick();
      end
      chk("abort_at_7", o_dump_addr, 7);
      i_reset = 1; m_clear(); #1;
      chk("abort_busy", o_busy, 0);
      chk("abort_valid", o_dump_valid, 0);
      @(posedge i_clk); #1 i_reset = 0;
      dones = 0;
      for (int i = 0; i < 40; i++) begin
         if (o_dump_done || o_dump_valid) dones++;
         tick();
      end
      chk("abort_quiet", dones, 0);
      drive(0, 1, 3'b010, 32'h00, 32'hFFFFFFFF, 2'b01, 0); tick();
      drive(1, 0, 3'b010, 32'h00, 0, 2'b01, 0); #1 chk("pre_rst_word", o_read_data, 32'hFFFFFFFF);
      do_reset();
      drive(1, 0, 3'b010, 32'h00, 0, 2'b01, 0); #1 chk("post_rst_word", o_read_data, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1);
   end
endmodule
